// File: rtl/acq_burst_sequencer_if.sv
// Gate-side signals of the burst sequencer: trigger/length out,
// monitored output handshake of the stream gate back in.
interface acq_burst_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic [CNT_WIDTH-1:0] samples;
    logic                 trig;
    logic                 mon_tvalid;
    logic                 mon_tready;
    logic                 mon_tlast;

    modport master (
        output samples,
        output trig,
        input  mon_tvalid,
        input  mon_tready,
        input  mon_tlast
    );

    modport slave (
        input  samples,
        input  trig,
        output mon_tvalid,
        output mon_tready,
        output mon_tlast
    );
endinterface

// File: rtl/acq_burst_sequencer.sv
// Run-level controller: fires a configured number of gate bursts,
// separated by an idle gap, and tracks completion via the gate output.
module acq_burst_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CNT_WIDTH-1:0]   cfg_samples,
    input  logic [BURST_WIDTH-1:0] cfg_bursts,
    input  logic [CNT_WIDTH-1:0]   cfg_gap,
    acq_burst_sequencer_if.master  gate,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] burst_cnt,
    output logic                   err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_RUN,
        S_GAP,
        S_END
    } state_t;

    state_t               state;
    logic [BURST_WIDTH-1:0] bursts_q;
    logic [CNT_WIDTH-1:0] gap_q;
    logic [CNT_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 stop_pend;

    logic                 beat;
    logic                 beat_max;
    logic                 stop_now;
    logic                 final_burst;
    logic [CNT_WIDTH-1:0] last_idx;
    logic [CNT_WIDTH-1:0] gap_last;

    assign beat        = gate.mon_tvalid & gate.mon_tready;
    assign beat_max    = &beat_cnt;
    assign stop_now    = stop_pend | stop;
    assign last_idx    = gate.samples - CNT_WIDTH'(1);
    assign gap_last    = gap_q - CNT_WIDTH'(1);
    assign final_burst = (burst_cnt + BURST_WIDTH'(1)) == bursts_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            gate.samples <= '0;
            gate.trig    <= 1'b0;
            bursts_q     <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            beat_cnt     <= '0;
            stop_pend    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            burst_cnt    <= '0;
            err          <= 1'b0;
        end else begin
            gate.trig <= 1'b0;
            done      <= 1'b0;
            if (state != S_IDLE && stop) begin
                stop_pend <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_samples != '0 && cfg_bursts != '0) begin
                            gate.samples <= cfg_samples;
                            bursts_q     <= cfg_bursts;
                            gap_q        <= cfg_gap;
                            burst_cnt    <= '0;
                            beat_cnt     <= '0;
                            err          <= 1'b0;
                            gate.trig    <= 1'b1;
                            busy         <= 1'b1;
                            state        <= S_TRIG;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_TRIG: state <= S_RUN;
                S_RUN: begin
                    if (beat && gate.mon_tlast) begin
                        burst_cnt <= burst_cnt + BURST_WIDTH'(1);
                        beat_cnt  <= '0;
                        if (beat_cnt != last_idx) begin
                            err <= 1'b1;
                        end
                        if (final_burst || stop_now) begin
                            done  <= 1'b1;
                            state <= S_END;
                        end else if (gap_q == '0) begin
                            gate.trig <= 1'b1;
                            state     <= S_TRIG;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (beat) begin
                        // saturate so a missing tlast never aliases to a short burst
                        if (!beat_max) begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                        if (beat_cnt == last_idx) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == gap_last) begin
                        if (stop_now) begin
                            done  <= 1'b1;
                            state <= S_END;
                        end else begin
                            gate.trig <= 1'b1;
                            state     <= S_TRIG;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + CNT_WIDTH'(1);
                    end
                end
                S_END: begin
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acq_burst_sequencer.sv
// Bench for acq_burst_sequencer: emulated gate output plus
// run-level timing/count model derived from the burst rules.
module tb_acq_burst_sequencer;
    localparam int CW = 32;
    localparam int BW = 16;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          stop;
    logic [CW-1:0] cfg_samples;
    logic [BW-1:0] cfg_bursts;
    logic [CW-1:0] cfg_gap;
    logic          busy;
    logic          done;
    logic [BW-1:0] burst_cnt;
    logic          err;

    acq_burst_sequencer_if #(.CNT_WIDTH(CW)) gif ();

    acq_burst_sequencer #(
        .CNT_WIDTH  (CW),
        .BURST_WIDTH(BW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .cfg_samples(cfg_samples),
        .cfg_bursts (cfg_bursts),
        .cfg_gap    (cfg_gap),
        .gate       (gif),
        .busy       (busy),
        .done       (done),
        .burst_cnt  (burst_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int trig_q[$];
    int last_q[$];
    int done_q[$];
    int wide_trig = 0;

    int e_len   = 4;
    int e_mode  = 0;
    int e_inj_b = -1;
    int e_inj_i = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: handshake values seen at the edge, then outputs of new cycle
    initial begin
        logic prev_trig;
        prev_trig = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gif.mon_tvalid && gif.mon_tready && gif.mon_tlast)
                last_q.push_back(cyc);
            cyc++;
            if (gif.trig === 1'b1) begin
                trig_q.push_back(cyc);
                if (prev_trig) wide_trig++;
            end
            prev_trig = (gif.trig === 1'b1);
            if (done === 1'b1) done_q.push_back(cyc);
        end
    end

    // Gate emulator: one burst of e_len beats per trig, optional early tlast
    initial begin
        bit arm;
        bit act;
        int idx;
        int cur_b;
        int lidx;
        arm = 0; act = 0; idx = 0; cur_b = 0;
        gif.mon_tvalid = 1'b0;
        gif.mon_tready = 1'b0;
        gif.mon_tlast  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn) begin
                arm = 0; act = 0; idx = 0;
            end else begin
                if (gif.mon_tvalid && gif.mon_tready) begin
                    if (gif.mon_tlast) act = 0;
                    else idx++;
                end
                if (arm) begin
                    act = 1; idx = 0; arm = 0;
                    cur_b = trig_q.size() - 1;
                end
                if (gif.trig === 1'b1) arm = 1;
            end
            case (e_mode)
                0:       gif.mon_tready = 1'b1;
                1:       gif.mon_tready = cyc[0];
                default: gif.mon_tready = 1'($urandom_range(0, 1));
            endcase
            lidx = (cur_b == e_inj_b) ? e_inj_i : e_len - 1;
            gif.mon_tvalid = act;
            gif.mon_tlast  = act && (idx == lidx);
        end
    end

    task automatic run(string nm, int s, int b, int g, int mode,
                       int inj_b, int inj_i, int stop_k);
        int exp_b;
        int st;
        int n;
        bit exp_err;
        bit stopped;
        exp_b   = (stop_k > 0 && stop_k < b) ? stop_k : b;
        exp_err = (inj_b >= 0) && (inj_b < exp_b) && (inj_i != s - 1);
        e_len = s; e_mode = mode; e_inj_b = inj_b; e_inj_i = inj_i;
        @(posedge clk);
        #3;
        trig_q.delete(); last_q.delete(); done_q.delete();
        wide_trig   = 0;
        cfg_samples = CW'(s);
        cfg_bursts  = BW'(b);
        cfg_gap     = CW'(g);
        start       = 1'b1;
        st          = cyc;
        @(posedge clk);
        #3;
        start = 1'b0;
        chk({nm, "_busy_on"}, busy, 1);
        chk({nm, "_err_clr"}, err, 0);
        n = 0; stopped = 0;
        while (done_q.size() == 0 && n < 3000) begin
            if (stop_k > 0 && !stopped && trig_q.size() == stop_k) begin
                stop = 1'b1; stopped = 1;
            end else begin
                stop = 1'b0;
            end
            @(posedge clk);
            #3;
            n++;
        end
        stop = 1'b0;
        chk({nm, "_no_timeout"}, n < 3000, 1);
        @(posedge clk);
        #3;
        chk({nm, "_busy_off"}, busy, 0);
        chk({nm, "_done_1cyc"}, done, 0);
        repeat (3) @(posedge clk);
        #3;
        chk({nm, "_trigs"}, trig_q.size(), exp_b);
        chk({nm, "_dones"}, done_q.size(), 1);
        chk({nm, "_bursts"}, burst_cnt, exp_b);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_samples"}, gif.samples, s);
        chk({nm, "_trig_width"}, wide_trig, 0);
        chk({nm, "_lastbeats"}, last_q.size(), exp_b);
        if (trig_q.size() > 0)
            chk({nm, "_first_trig"}, trig_q[0], st + 1);
        for (int k = 0; k + 1 < exp_b; k++) begin
            if (k + 1 < trig_q.size() && k < last_q.size())
                chk($sformatf("%s_spacing%0d", nm, k),
                    trig_q[k+1] - last_q[k], g + 1);
        end
        if (done_q.size() > 0 && last_q.size() > 0)
            chk({nm, "_done_time"}, done_q[0],
                last_q[last_q.size()-1] + 1);
    endtask

    task automatic bad_start(string nm, int s, int b);
        @(posedge clk);
        #3;
        trig_q.delete(); done_q.delete();
        cfg_samples = CW'(s);
        cfg_bursts  = BW'(b);
        cfg_gap     = CW'(1);
        start       = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        chk({nm, "_err"}, err, 1);
        chk({nm, "_busy"}, busy, 0);
        repeat (6) @(posedge clk);
        #3;
        chk({nm, "_no_trig"}, trig_q.size(), 0);
        chk({nm, "_no_done"}, done_q.size(), 0);
    endtask

    initial begin
        int n;
        resetn = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_samples = '0; cfg_bursts = '0; cfg_gap = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_samples", gif.samples, 0);
        chk("rst_trig", gif.trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_err", err, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        run("base", 4, 3, 5, 0, -1, 0, 0);
        run("bp_gap0", 4, 3, 0, 1, -1, 0, 0);
        run("stop", 4, 5, 2, 0, -1, 0, 2);
        bad_start("zero_samples", 0, 3);
        run("clr", 3, 2, 1, 0, -1, 0, 0);
        bad_start("zero_bursts", 4, 0);
        run("tlast_early", 4, 3, 2, 0, 1, 1, 0);
        run("single", 1, 2, 0, 2, -1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            run($sformatf("rnd%0d", r),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                -1, 0, 0);
        end

        e_len = 4; e_mode = 0; e_inj_b = -1;
        @(posedge clk);
        #3;
        trig_q.delete(); last_q.delete(); done_q.delete();
        cfg_samples = CW'(4); cfg_bursts = BW'(3); cfg_gap = CW'(10);
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        n = 0;
        while (last_q.size() == 0 && n < 200) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("rst_mid_reach_gap", n < 200, 1);
        @(posedge clk);
        #3;
        chk("rst_mid_pre_bursts", burst_cnt, 1);
        chk("rst_mid_pre_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_samples", gif.samples, 0);
        chk("rst_mid_trig", gif.trig, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_burst_cnt", burst_cnt, 0);
        chk("rst_mid_err", err, 0);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        trig_q.delete();
        repeat (20) @(posedge clk);
        #3;
        chk("rst_mid_no_trig", trig_q.size(), 0);
        chk("rst_mid_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
